// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared BCD constants, preset ranges and conversion helpers
//               for the timer datapath counters.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  localparam int BCD_W   = 4;
  localparam int MAX_DIG = 4;
  localparam int FULL_W  = MAX_DIG * BCD_W;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MIN = 1;
  localparam int HR12_MAX = 12;

  function automatic logic [FULL_W-1:0] int_to_bcd(input int unsigned val);
    logic [FULL_W-1:0] r;
    int unsigned       v;
    r = '0;
    v = val;
    for (int i = 0; i < MAX_DIG; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int unsigned bcd_to_bin(input logic [FULL_W-1:0] bcd);
    int unsigned r;
    r = 0;
    for (int i = MAX_DIG - 1; i >= 0; i--) begin
      r = r * 10 + 32'(bcd[i*BCD_W +: BCD_W]);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_step
// Description : Combinational single BCD digit increment/decrement cell with
//               ripple carry/borrow in and out.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_step
  import timer_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic             cin_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             cout_o
);

  always_comb begin
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (digit_i >= 4'd9) begin
          digit_o = 4'd0;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else if (down_i) begin
        if (digit_i == 4'd0) begin
          digit_o = 4'd9;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mod_counter
// Description : Multi-digit BCD modulo counter with up/down stepping, wrap
//               carry/borrow pulses and range-checked parallel load.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
  import timer_pkg::*;
#(
  parameter int NDIG    = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  hold,
  input  logic                  load,
  input  logic [4*NDIG-1:0]     load_val,
  output logic [4*NDIG-1:0]     out_q,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err
);

  localparam int                W        = NDIG * BCD_W;
  localparam int unsigned       MIN_U    = MIN_VAL;
  localparam int unsigned       MAX_U    = MAX_VAL;
  localparam logic [FULL_W-1:0] MIN_FULL = int_to_bcd(MIN_U);
  localparam logic [FULL_W-1:0] MAX_FULL = int_to_bcd(MAX_U);
  localparam logic [W-1:0]      MIN_BCD  = MIN_FULL[W-1:0];
  localparam logic [W-1:0]      MAX_BCD  = MAX_FULL[W-1:0];

  logic [W-1:0]      cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              err_q, err_d;

  logic [W-1:0]      step_val;
  logic [NDIG:0]     chain;
  logic              unused_cout;
  logic              step_up, step_dn;
  logic [FULL_W-1:0] load_pad;
  int unsigned       load_bin;
  logic              digits_ok;
  logic              load_ok;

  assign step_up  = inc & ~dec;
  assign step_dn  = dec & ~inc;
  assign chain[0] = 1'b1;

  // Ripple chain: the units digit always steps, higher digits step on carry-in.
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit_i (cnt_q[g*BCD_W +: BCD_W]),
      .up_i    (step_up),
      .down_i  (step_dn),
      .cin_i   (chain[g]),
      .digit_o (step_val[g*BCD_W +: BCD_W]),
      .cout_o  (chain[g+1])
    );
  end

  // Top-digit overflow cannot occur: wrap at MAX_VAL takes over first.
  assign unused_cout = chain[NDIG];

  assign load_pad = FULL_W'(load_val);
  assign load_bin = bcd_to_bin(load_pad);

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (load_val[i*BCD_W +: BCD_W] > 4'd9) digits_ok = 1'b0;
    end
  end

  assign load_ok = digits_ok && (load_bin >= MIN_U) && (load_bin <= MAX_U);

  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (load) begin
      if (load_ok) cnt_d = load_val;
      else         err_d = 1'b1;
    end else if (!hold) begin
      if (step_up) begin
        if (cnt_q == MAX_BCD) begin
          cnt_d   = MIN_BCD;
          carry_d = 1'b1;
        end else begin
          cnt_d = step_val;
        end
      end else if (step_dn) begin
        if (cnt_q == MIN_BCD) begin
          cnt_d    = MAX_BCD;
          borrow_d = 1'b1;
        end else begin
          cnt_d = step_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= MIN_BCD;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign out_q    = cnt_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = err_q;

endmodule
`default_nettype wire
